// File: rtl/controller_feeder_if.sv
// Beat memory read port and controller lane bus for the controller feeder.
// Latency: n/a (wires only). Backpressure: din_ready from the controller side.
// Ports: master = feeder side (drives reads, start, lanes); slave = memory/controller side.
interface controller_feeder_if #(
  parameter int N  = 6,
  parameter int DW = 16,
  parameter int AW = 12
);
  // beat memory, 1-cycle read latency
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_addr;
  logic [N*DW-1:0]      mem_rd_data;
  // controller input interface
  logic                 start;
  logic [N-1:0]         weight_en;
  logic                 state;
  logic                 din_valid;
  logic signed [DW-1:0] din_0;
  logic signed [DW-1:0] din_1;
  logic signed [DW-1:0] din_2;
  logic signed [DW-1:0] din_3;
  logic signed [DW-1:0] din_4;
  logic signed [DW-1:0] din_5;
  logic                 din_ready;
  logic [N-1:0]         done;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output start, weight_en, state, din_valid,
    output din_0, din_1, din_2, din_3, din_4, din_5,
    input  din_ready, done
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  start, weight_en, state, din_valid,
    input  din_0, din_1, din_2, din_3, din_4, din_5,
    output din_ready, done
  );
endinterface

// File: rtl/controller_feeder.sv
// Streams a weight frame then an activation frame from beat memory into the controller's 6 lanes.
// Latency: first din_valid 2 cycles after a phase begins, then up to 1 beat/cycle.
// Backpressure: din_ready stalls lanes; reads throttled so FIFO entries + in-flight reads never exceed 2.
// Ports: clk/rst (async active-high); go, w_base/w_len, a_base/a_len, w_mask job request;
//        bus (master) carries memory reads and controller lanes; busy/finish/timeout status.
module controller_feeder #(
  parameter int N   = 6,
  parameter int DW  = 16,
  parameter int AW  = 12,
  parameter int LW  = 12,
  parameter int TMO = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [AW-1:0] w_base,
  input  logic [LW-1:0] w_len,
  input  logic [AW-1:0] a_base,
  input  logic [LW-1:0] a_len,
  input  logic [N-1:0]  w_mask,
  controller_feeder_if.master bus,
  output logic          busy,
  output logic          finish,
  output logic          timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WLOAD = 3'd2,
    S_ACT   = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t state_q, state_d;

  // job parameters captured on go
  logic [AW-1:0] w_base_q, a_base_q;
  logic [LW-1:0] w_len_q, a_len_q;
  logic [N-1:0]  mask_q;

  // per-phase progress
  logic [LW-1:0] issued_q;
  logic [LW-1:0] popped_q;
  logic          inflight_q;

  // 2-entry FIFO: head_q is always the oldest entry and drives the lanes
  logic [1:0]      fifo_cnt_q;
  logic [N*DW-1:0] head_q, tail_q;

  logic [31:0] tmo_cnt_q;
  logic        timeout_q;

  logic          in_xfer;
  logic [LW-1:0] cur_len;
  logic [AW-1:0] cur_base;
  logic          din_valid;
  logic          pop, push, last_pop;
  logic [2:0]    occ, cap;
  logic          rd_en;
  logic          done_ok;
  logic          tmo_hit;

  always_comb begin
    in_xfer   = (state_q == S_WLOAD) || (state_q == S_ACT);
    cur_len   = (state_q == S_ACT) ? a_len_q  : w_len_q;
    cur_base  = (state_q == S_ACT) ? a_base_q : w_base_q;
    din_valid = in_xfer && (fifo_cnt_q != 2'd0);
    pop       = din_valid && bus.din_ready;
    push      = inflight_q;
    last_pop  = pop && (popped_q == cur_len - LW'(1));
    // A pop this cycle frees a slot by the time the new read lands, so count it
    // as credit; without it the stream could not reach one beat per cycle.
    occ       = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    cap       = 3'd2 + {2'b00, pop};
    rd_en     = in_xfer && (issued_q < cur_len) && (occ < cap);
    done_ok   = (bus.done & mask_q) == mask_q;
    tmo_hit   = (TMO != 0) && (tmo_cnt_q == 32'(TMO - 1));
  end

  // next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_START;
      S_START: begin
        if (w_len_q != '0)      state_d = S_WLOAD;
        else if (a_len_q != '0) state_d = S_ACT;
        else                    state_d = S_DRAIN;
      end
      S_WLOAD: if (last_pop) state_d = (a_len_q != '0) ? S_ACT : S_DRAIN;
      S_ACT:   if (last_pop) state_d = S_DRAIN;
      S_DRAIN: if (done_ok || tmo_hit) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // job latch and sticky timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_base_q  <= '0;
      a_base_q  <= '0;
      w_len_q   <= '0;
      a_len_q   <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == S_IDLE && go) begin
      w_base_q  <= w_base;
      a_base_q  <= a_base;
      w_len_q   <= w_len;
      a_len_q   <= a_len;
      mask_q    <= w_mask;
      timeout_q <= 1'b0;
    end else if (state_q == S_DRAIN && !done_ok && tmo_hit) begin
      timeout_q <= 1'b1;
    end
  end

  // Counters restart at each phase boundary so the next phase refetches from its own base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      if (!in_xfer || last_pop) begin
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (rd_en) issued_q <= issued_q + LW'(1);
        if (pop)   popped_q <= popped_q + LW'(1);
      end
    end
  end

  // The head only changes when popped or when an empty FIFO receives a beat,
  // so the lanes never move while a beat is presented but not yet taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt_q <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      unique case (fifo_cnt_q)
        2'd0: begin
          if (push) begin
            head_q     <= bus.mem_rd_data;
            fifo_cnt_q <= 2'd1;
          end
        end
        2'd1: begin
          unique case ({push, pop})
            2'b11: head_q <= bus.mem_rd_data;
            2'b10: begin
              tail_q     <= bus.mem_rd_data;
              fifo_cnt_q <= 2'd2;
            end
            2'b01: fifo_cnt_q <= 2'd0;
            default: ;
          endcase
        end
        2'd2: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) tail_q     <= bus.mem_rd_data;
            else      fifo_cnt_q <= 2'd1;
          end
        end
        default: fifo_cnt_q <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tmo_cnt_q <= '0;
    else if (state_q != S_DRAIN) tmo_cnt_q <= '0;
    else                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
  end

  // read port is quiet (address 0) whenever no read is issued
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = rd_en ? (cur_base + AW'(issued_q)) : '0;

  assign bus.start     = (state_q == S_START);
  assign bus.weight_en = (state_q == S_WLOAD) ? mask_q : '0;
  assign bus.state     = (state_q == S_ACT) || (state_q == S_DRAIN);
  assign bus.din_valid = din_valid;
  assign bus.din_0     = head_q[0*DW +: DW];
  assign bus.din_1     = head_q[1*DW +: DW];
  assign bus.din_2     = head_q[2*DW +: DW];
  assign bus.din_3     = head_q[3*DW +: DW];
  assign bus.din_4     = head_q[4*DW +: DW];
  assign bus.din_5     = head_q[5*DW +: DW];

  assign busy    = (state_q != S_IDLE);
  assign finish  = (state_q == S_FIN);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_controller_feeder.sv
// Directed bench for controller_feeder: memory model, lane monitor, linear test sequence.
// Latency: n/a. Backpressure: din_ready held high or toggled per test.
// Ports: none; instantiates controller_feeder_if and controller_feeder.
module tb_controller_feeder;
  localparam int N = 6, DW = 16, AW = 12, LW = 12, TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic [AW-1:0] w_base = '0, a_base = '0;
  logic [LW-1:0] w_len = '0, a_len = '0;
  logic [N-1:0]  w_mask = '0;
  logic          busy, finish, timeout;

  controller_feeder_if #(.N(N), .DW(DW), .AW(AW)) bus ();

  controller_feeder #(.N(N), .DW(DW), .AW(AW), .LW(LW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .go(go),
    .w_base(w_base), .w_len(w_len), .a_base(a_base), .a_len(a_len), .w_mask(w_mask),
    .bus(bus), .busy(busy), .finish(finish), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*DW-1:0] dat;
    logic            st;
    logic [N-1:0]    we;
  } beat_t;

  int n_checks = 0, n_fail = 0;

  // monitor state
  beat_t         beats[$];
  logic [AW-1:0] addrs[$];
  int cyc = 0, n_start = 0, n_fin = 0, start_cyc = -1, fin_cyc = -1, first_valid = -1;
  int rd_tot = 0, pop_tot = 0, max_out = 0, stab_err = 0;
  logic prev_hold = 1'b0;
  logic [N*DW-1:0] prev_dat = '0;
  logic ready_toggle = 1'b0;

  function automatic logic [N*DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [N*DW-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) w[i*DW +: DW] = {a, 1'b0, 3'(i)};
    return w;
  endfunction

  function automatic logic [N*DW-1:0] din_bus();
    return {bus.din_5, bus.din_4, bus.din_3, bus.din_2, bus.din_1, bus.din_0};
  endfunction

  function automatic logic [127:0] outs();
    return 128'({busy, finish, timeout, bus.start, bus.weight_en, bus.state, bus.din_valid,
                 bus.mem_rd_en, bus.mem_addr, din_bus()});
  endfunction

  // beat memory, one-cycle read latency
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(bus.mem_addr);

  // din_ready driver: steady 1, or alternating when ready_toggle is set
  initial begin
    bus.din_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle) bus.din_ready = ~bus.din_ready;
      else              bus.din_ready = 1'b1;
    end
  end

  // monitor sampled on the falling edge
  always @(negedge clk) begin
    int out;
    cyc++;
    out = rd_tot - pop_tot;
    if (out > max_out) max_out = out;
    if (bus.start) begin start_cyc = cyc; n_start++; end
    if (finish)    begin fin_cyc = cyc; n_fin++; end
    if (bus.din_valid && first_valid < 0) first_valid = cyc;
    if (prev_hold && (!bus.din_valid || din_bus() !== prev_dat)) stab_err++;
    prev_hold = bus.din_valid && !bus.din_ready;
    prev_dat  = din_bus();
    if (bus.mem_rd_en) begin rd_tot++; addrs.push_back(bus.mem_addr); end
    if (bus.din_valid && bus.din_ready) begin
      pop_tot++;
      beats.push_back(beat_t'{dat: din_bus(), st: bus.state, we: bus.weight_en});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    beats.delete();
    addrs.delete();
    n_start = 0; start_cyc = -1; fin_cyc = -1; first_valid = -1;
    rd_tot = 0; pop_tot = 0; max_out = 0; stab_err = 0;
  endtask

  task automatic launch(input logic [AW-1:0] wb, input logic [LW-1:0] wl,
                        input logic [AW-1:0] ab, input logic [LW-1:0] al, input logic [N-1:0] m);
    clear_mon();
    w_base = wb; w_len = wl; a_base = ab; a_len = al; w_mask = m;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic run(input string tag, input logic [AW-1:0] wb, input logic [LW-1:0] wl,
                     input logic [AW-1:0] ab, input logic [LW-1:0] al, input logic [N-1:0] m);
    int fin0;
    fin0 = n_fin;
    launch(wb, wl, ab, al, m);
    for (int k = 0; k < 300 && n_fin == fin0; k++) tick();
    chk({tag, "_finish_pulses"}, 128'(n_fin - fin0), 128'(1));
    chk({tag, "_start_pulses"}, 128'(n_start), 128'(1));
    tick();
    chk({tag, "_idle_after"}, 128'({busy, finish}), 128'(0));
  endtask

  task automatic chk_beats(input string tag, input logic [AW-1:0] wb, input logic [LW-1:0] wl,
                           input logic [AW-1:0] ab, input logic [LW-1:0] al, input logic [N-1:0] m);
    int total;
    beat_t e;
    total = int'(wl) + int'(al);
    chk({tag, "_beat_count"}, 128'(beats.size()), 128'(total));
    for (int j = 0; j < total && j < beats.size(); j++) begin
      if (j < int'(wl)) e = beat_t'{dat: mem_word(wb + AW'(j)), st: 1'b0, we: m};
      else              e = beat_t'{dat: mem_word(ab + AW'(j - int'(wl))), st: 1'b1, we: '0};
      chk($sformatf("%s_beat%0d", tag, j), 128'(beats[j]), 128'(e));
    end
  endtask

  initial begin
    logic [AW-1:0] exp_addr[4];
    int fin0, act_n;
    bus.done = 6'h3F;

    // reset state
    tick();
    tick();
    chk("reset_outputs", outs(), 128'(0));
    rst = 1'b0;
    tick();
    chk("post_reset_outputs", outs(), 128'(0));

    // 1: basic frame, ready held high
    run("t1", 12'h000, 12'd4, 12'h010, 12'd8, 6'h3F);
    chk_beats("t1", 12'h000, 12'd4, 12'h010, 12'd8, 6'h3F);
    chk("t1_first_valid_lat", 128'(first_valid - start_cyc), 128'(3));
    chk("t1_finish_lat", 128'(fin_cyc - start_cyc), 128'(18));
    chk("t1_timeout", 128'(timeout), 128'(0));

    // 2: din_ready toggling
    ready_toggle = 1'b1;
    run("t2", 12'h000, 12'd4, 12'h010, 12'd8, 6'h3F);
    ready_toggle = 1'b0;
    chk_beats("t2", 12'h000, 12'd4, 12'h010, 12'd8, 6'h3F);
    chk("t2_stable_while_held", 128'(stab_err), 128'(0));
    chk("t2_fifo_le_2", 128'(max_out <= 2), 128'(1));

    // 3: empty frames
    run("t3", 12'h000, 12'd0, 12'h000, 12'd0, 6'h3F);
    chk("t3_no_reads", 128'(addrs.size()), 128'(0));
    chk("t3_no_beats", 128'(beats.size()), 128'(0));
    chk("t3_finish_lat", 128'(fin_cyc - start_cyc), 128'(2));

    // 4: timeout, stickiness, clear on next go, partial mask completion
    bus.done = 6'h00;
    run("t4", 12'h000, 12'd0, 12'h000, 12'd0, 6'h3F);
    chk("t4_finish_lat", 128'(fin_cyc - start_cyc), 128'(17));
    chk("t4_timeout_set", 128'(timeout), 128'(1));
    tick();
    tick();
    chk("t4_timeout_sticky", 128'(timeout), 128'(1));
    bus.done = 6'h15;
    launch(12'h000, 12'd0, 12'h000, 12'd0, 6'h15);
    chk("t4_timeout_cleared_by_go", 128'(timeout), 128'(0));
    fin0 = n_fin;
    for (int k = 0; k < 50 && n_fin == fin0; k++) tick();
    chk("t4_mask_finish_lat", 128'(fin_cyc - start_cyc), 128'(2));
    chk("t4_mask_no_timeout", 128'(timeout), 128'(0));
    bus.done = 6'h3F;
    tick();

    // 5: address wrap
    exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
    run("t5", 12'h000, 12'd0, 12'hFFE, 12'd4, 6'h3F);
    chk("t5_read_count", 128'(addrs.size()), 128'(4));
    for (int j = 0; j < 4 && j < addrs.size(); j++)
      chk($sformatf("t5_addr%0d", j), 128'(addrs[j]), 128'(exp_addr[j]));
    chk_beats("t5", 12'h000, 12'd0, 12'hFFE, 12'd4, 6'h3F);

    // 6: reset in the middle of the activation phase
    fin0 = n_fin;
    launch(12'h000, 12'd4, 12'h010, 12'd8, 6'h3F);
    act_n = 0;
    for (int k = 0; k < 100; k++) begin
      act_n = 0;
      foreach (beats[j]) if (beats[j].st) act_n++;
      if (act_n >= 3) break;
      tick();
    end
    chk("t6_reached_act", 128'(act_n >= 3), 128'(1));
    chk("t6_busy_before_rst", 128'({busy, bus.state}), 128'(2'b11));
    rst = 1'b1;
    tick();
    chk("t6_outputs_in_rst", outs(), 128'(0));
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t6_outputs_after_rst", outs(), 128'(0));
    chk("t6_no_finish", 128'(n_fin - fin0), 128'(0));
    run("t6r", 12'h000, 12'd4, 12'h010, 12'd8, 6'h3F);
    chk_beats("t6r", 12'h000, 12'd4, 12'h010, 12'd8, 6'h3F);
    chk("t6r_finish_lat", 128'(fin_cyc - start_cyc), 128'(18));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
